param_cache: RTL and testbench
==============================

PARAM_CACHE -- requirements
Module: param_cache

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-002 SHALL have parameter WORD_WIDTH, default 32, data word width; WORD_BYTES = WORD_WIDTH/8.
REQ-003 SHALL have parameter WAYS, default 4, associativity, power of 2, at least 2.
REQ-004 SHALL have parameter SETS, default 16, set count, power of 2.
REQ-005 SHALL have parameter LINE_WORDS, default 4, words per line, power of 2; LINE_WIDTH = LINE_WORDS*WORD_WIDTH.
REQ-006 SHALL split the address as follows:
- OFFSET = log2(LINE_WORDS*WORD_BYTES) low bits;
- INDEX = log2(SETS) next bits;
- TAG = remaining upper bits.
REQ-007 SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  CPU request present.
- req_ready  out  1  request accepted when high with req_valid; equals (state==IDLE).
- req_wr  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH  word-aligned address.
- req_wdata  in  WORD_WIDTH  store data.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  WORD_WIDTH  word at the request address after the operation.
- wb_valid  out  1  dirty-line write-back offer.
- wb_ready  in  1  write buffer accepts the line.
- wb_addr  out  ADDR_WIDTH  line-aligned victim address.
- wb_data  out  LINE_WIDTH  victim line, word 0 in the LSBs.
- mem_rd_req  out  1  refill request.
- mem_rd_addr  out  ADDR_WIDTH  line-aligned refill address.
- mem_rd_valid  in  1  refill data valid, single beat.
- mem_rd_data  in  LINE_WIDTH  refill line, word 0 in the LSBs.

Function
REQ-008 SHALL be write-back, write-allocate, and handle one outstanding request; per line it SHALL store valid, dirty, tag and data; per set it SHALL store a log2(WAYS) round-robin pointer.
REQ-009 SHALL use the FSM states IDLE, LOOKUP, WB, REFILL and RESP.
REQ-010 SHALL, in IDLE, register req_wr, req_addr and req_wdata on req_valid&req_ready and go to LOOKUP; otherwise it SHALL stay in IDLE.
REQ-011 SHALL, in LOOKUP on a hit (a valid way with a matching tag), perform the following and go to RESP:
- load: latch the selected word;
- store: write req_wdata into the word, set dirty, latch the new word.
REQ-012 SHALL assert resp_valid for exactly the RESP cycle, then return to IDLE; hit latency is acceptance cycle T to resp_valid at T+2.
REQ-013 SHALL, in LOOKUP on a miss, choose the victim as the lowest-index invalid way if any, else the way at the set's round-robin pointer.
REQ-014 SHALL, on a miss with a valid, dirty victim, go to WB; otherwise it SHALL go to REFILL.
REQ-015 SHALL, in WB, hold wb_valid=1 and stable wb_addr {victim tag, index, 0} and wb_data until wb_ready, then go to REFILL; it SHALL not raise mem_rd_req before that handshake.
REQ-016 SHALL, in REFILL, hold mem_rd_req=1 and mem_rd_addr {req tag, index, 0} until mem_rd_valid.
REQ-017 SHALL, on mem_rd_valid, write the line, set valid, clear dirty, write the tag, set the pointer to (victim+1) mod WAYS, and return to LOOKUP; the retry hits and a store merges its data then.
REQ-018 SHALL ignore mem_rd_valid outside REFILL and wb_ready outside WB.
REQ-019 SHALL keep wb_valid and mem_rd_req at 0 in all states other than WB and REFILL respectively.
REQ-020 SHALL never have more than one way hit in a set; tag compare uses only valid ways.

Reset
REQ-021 SHALL, on rst_n=0 and regardless of state, immediately do all of the following:
- go to IDLE;
- clear every valid and dirty bit and every round-robin pointer;
- drive resp_valid, resp_rdata, wb_valid, wb_addr, wb_data, mem_rd_req and mem_rd_addr to 0.
REQ-022 SHALL drive req_ready to 1 during and after reset, since the state is IDLE.
REQ-023 SHALL discard any in-flight request on reset and issue no response for it; data arrays need no reset.

Verification
Default parameters; memory line n returns {n,n,n,n}.
REQ-024 SHALL be verified by a cold load of 0x10: expect mem_rd_addr=0x10, no wb_valid, resp_rdata=1, resp_valid once.
REQ-025 SHALL be verified by repeating the 0x10 load: expect resp_valid at T+2 and mem_rd_req never set.
REQ-026 SHALL be verified by storing 0xDEADBEEF to 0x14 and then loading 0x14: expect a hit with no memory traffic, the line dirty, and a resp_rdata of 0xDEADBEEF.
REQ-027 SHALL be verified by loading 0x110, 0x210, 0x310 then 0x410, with wb_ready held low for 3 cycles:
- the 0x410 load evicts way 0;
- wb_addr=0x10, wb_data word1=0xDEADBEEF;
- wb_valid held for 4 cycles;
- mem_rd_req is raised only after acceptance.
REQ-028 SHALL be verified by asserting rst_n=0 during REFILL: expect all outputs 0 and no resp_valid; a subsequent load of 0x10 misses again.
REQ-029 SHALL be verified with WAYS=2, SETS=64, LINE_WORDS=8 and a load of 0x124: expect mem_rd_addr=0x120 and resp_rdata = word 1 of line 9.

Source files
------------

// File: rtl/param_cache.sv
// param_cache: set-associative, write-back / write-allocate data cache.
// One outstanding CPU request. Dirty victims are offered as whole lines on the
// wb_* port, and refills arrive as single-beat lines on the mem_rd_* port.
module param_cache #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned WAYS       = 4,
  parameter int unsigned SETS       = 16,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_wr,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [WORD_WIDTH-1:0]            req_wdata,
  output logic                             resp_valid,
  output logic [WORD_WIDTH-1:0]            resp_rdata,
  output logic                             wb_valid,
  input  logic                             wb_ready,
  output logic [ADDR_WIDTH-1:0]            wb_addr,
  output logic [LINE_WORDS*WORD_WIDTH-1:0] wb_data,
  output logic                             mem_rd_req,
  output logic [ADDR_WIDTH-1:0]            mem_rd_addr,
  input  logic                             mem_rd_valid,
  input  logic [LINE_WORDS*WORD_WIDTH-1:0] mem_rd_data
);

  localparam int unsigned WORD_BYTES = WORD_WIDTH / 8;
  localparam int unsigned LINE_WIDTH = LINE_WORDS * WORD_WIDTH;
  localparam int unsigned BYTE_W     = $clog2(WORD_BYTES);
  localparam int unsigned WSEL_W     = $clog2(LINE_WORDS);
  localparam int unsigned OFFSET_W   = BYTE_W + WSEL_W;
  localparam int unsigned INDEX_W    = $clog2(SETS);
  localparam int unsigned TAG_W      = ADDR_WIDTH - OFFSET_W - INDEX_W;
  localparam int unsigned WAY_W      = $clog2(WAYS);

  typedef enum logic [2:0] {IDLE, LOOKUP, WB, REFILL, RESP} state_t;

  state_t                  state_q;

  logic                    req_wr_q;
  logic [TAG_W-1:0]        req_tag_q;
  logic [INDEX_W-1:0]      req_idx_q;
  logic [WSEL_W-1:0]       req_wsel_q;
  logic [WORD_WIDTH-1:0]   req_wdata_q;
  logic [WAY_W-1:0]        victim_q;

  logic [WAYS-1:0]         valid_q [SETS];
  logic [WAYS-1:0]         dirty_q [SETS];
  logic [WAY_W-1:0]        rr_q    [SETS];
  logic [TAG_W-1:0]        tag_q   [SETS][WAYS];
  logic [LINE_WIDTH-1:0]   data_q  [SETS][WAYS];

  logic                    resp_valid_q;
  logic [WORD_WIDTH-1:0]   resp_rdata_q;
  logic                    wb_valid_q;
  logic [ADDR_WIDTH-1:0]   wb_addr_q;
  logic [LINE_WIDTH-1:0]   wb_data_q;
  logic                    mem_rd_req_q;
  logic [ADDR_WIDTH-1:0]   mem_rd_addr_q;

  logic                    hit;
  logic [WAY_W-1:0]        hit_way;
  logic                    inv_found;
  logic [WAY_W-1:0]        inv_way;
  logic [WAY_W-1:0]        victim_d;
  logic [LINE_WIDTH-1:0]   sel_line;
  logic [WORD_WIDTH-1:0]   sel_word;
  logic [ADDR_WIDTH-1:0]   refill_addr;
  logic                    unused_byte_bits;

  // Byte-within-word address bits carry no information for word-aligned requests.
  assign unused_byte_bits = ^req_addr[BYTE_W-1:0];

  assign req_ready   = (state_q == IDLE);
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign wb_valid    = wb_valid_q;
  assign wb_addr     = wb_addr_q;
  assign wb_data     = wb_data_q;
  assign mem_rd_req  = mem_rd_req_q;
  assign mem_rd_addr = mem_rd_addr_q;

  assign refill_addr = {req_tag_q, req_idx_q, {OFFSET_W{1'b0}}};
  assign sel_line    = data_q[req_idx_q][hit_way];
  assign sel_word    = sel_line[req_wsel_q*WORD_WIDTH +: WORD_WIDTH];

  // Tag match over valid ways, and victim choice: first invalid way, else round-robin.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx_q][WAY_W'(w)] && (tag_q[req_idx_q][WAY_W'(w)] == req_tag_q)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[req_idx_q][WAY_W'(w)] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    victim_d = inv_found ? inv_way : rr_q[req_idx_q];
  end

  // Tag and data arrays: line fill on refill, word merge on a store hit. No reset needed.
  always_ff @(posedge clk) begin
    if ((state_q == REFILL) && mem_rd_valid) begin
      data_q[req_idx_q][victim_q] <= mem_rd_data;
      tag_q[req_idx_q][victim_q]  <= req_tag_q;
    end else if ((state_q == LOOKUP) && hit && req_wr_q) begin
      data_q[req_idx_q][hit_way][req_wsel_q*WORD_WIDTH +: WORD_WIDTH] <= req_wdata_q;
    end
  end

  // Control FSM with registered outputs, line status bits and replacement pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      req_wr_q      <= 1'b0;
      req_tag_q     <= '0;
      req_idx_q     <= '0;
      req_wsel_q    <= '0;
      req_wdata_q   <= '0;
      victim_q      <= '0;
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        rr_q[s]    <= '0;
      end
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= '0;
      wb_valid_q    <= 1'b0;
      wb_addr_q     <= '0;
      wb_data_q     <= '0;
      mem_rd_req_q  <= 1'b0;
      mem_rd_addr_q <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            req_wr_q    <= req_wr;
            req_tag_q   <= req_addr[ADDR_WIDTH-1 -: TAG_W];
            req_idx_q   <= req_addr[OFFSET_W +: INDEX_W];
            req_wsel_q  <= req_addr[BYTE_W +: WSEL_W];
            req_wdata_q <= req_wdata;
            state_q     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            resp_rdata_q <= req_wr_q ? req_wdata_q : sel_word;
            if (req_wr_q) begin
              dirty_q[req_idx_q][hit_way] <= 1'b1;
            end
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end else begin
            victim_q <= victim_d;
            if (valid_q[req_idx_q][victim_d] && dirty_q[req_idx_q][victim_d]) begin
              wb_valid_q <= 1'b1;
              wb_addr_q  <= {tag_q[req_idx_q][victim_d], req_idx_q, {OFFSET_W{1'b0}}};
              wb_data_q  <= data_q[req_idx_q][victim_d];
              state_q    <= WB;
            end else begin
              mem_rd_req_q  <= 1'b1;
              mem_rd_addr_q <= refill_addr;
              state_q       <= REFILL;
            end
          end
        end
        WB: begin
          if (wb_ready) begin
            wb_valid_q    <= 1'b0;
            mem_rd_req_q  <= 1'b1;
            mem_rd_addr_q <= refill_addr;
            state_q       <= REFILL;
          end
        end
        REFILL: begin
          // Refill only installs the line; the retried lookup then hits and merges a store.
          if (mem_rd_valid) begin
            mem_rd_req_q                 <= 1'b0;
            valid_q[req_idx_q][victim_q] <= 1'b1;
            dirty_q[req_idx_q][victim_q] <= 1'b0;
            rr_q[req_idx_q]              <= victim_q + WAY_W'(1);
            state_q                      <= LOOKUP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_cache.sv
// tb_param_cache: randomized and directed stimulus with a scoreboard checked
// against a word-level memory model (CPU view = stores over backing memory).
module tb_param_cache;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic         req_valid, req_ready, req_wr;
  logic [31:0]  req_addr, req_wdata;
  logic         resp_valid;
  logic [31:0]  resp_rdata;
  logic         wb_valid, wb_ready;
  logic [31:0]  wb_addr;
  logic [127:0] wb_data;
  logic         mem_rd_req;
  logic [31:0]  mem_rd_addr;
  logic         mem_rd_valid;
  logic [127:0] mem_rd_data;

  // Small-geometry instance
  logic         b_req_valid, b_req_ready, b_req_wr;
  logic [31:0]  b_req_addr, b_req_wdata;
  logic         b_resp_valid;
  logic [31:0]  b_resp_rdata;
  logic         b_wb_valid, b_wb_ready;
  logic [31:0]  b_wb_addr;
  logic [255:0] b_wb_data;
  logic         b_mem_rd_req;
  logic [31:0]  b_mem_rd_addr;
  logic         b_mem_rd_valid;
  logic [255:0] b_mem_rd_data;

  param_cache dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data)
  );

  param_cache #(.ADDR_WIDTH(32), .WORD_WIDTH(32), .WAYS(2), .SETS(64), .LINE_WORDS(8)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wr(b_req_wr),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata),
    .wb_valid(b_wb_valid), .wb_ready(b_wb_ready), .wb_addr(b_wb_addr), .wb_data(b_wb_data),
    .mem_rd_req(b_mem_rd_req), .mem_rd_addr(b_mem_rd_addr),
    .mem_rd_valid(b_mem_rd_valid), .mem_rd_data(b_mem_rd_data)
  );

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int unsigned t;
    bit          lat;
  } exp_t;

  exp_t         sbq[$];
  logic [127:0] bmem [int unsigned];
  logic [31:0]  wr   [int unsigned];
  logic [31:0]  cur_addr = '0;

  // Environment knobs and observation counters
  bit           spur_en = 0;
  bit           mem_stall = 0;
  int unsigned  wb_hold = 0;
  int unsigned  mem_dly_max = 2;
  int unsigned  req_seen = 0, rd_cnt = 0, wb_seen = 0, wb_cnt = 0;
  logic [31:0]  last_rd_addr = '0, last_wb_addr = '0;
  logic [127:0] last_wb_data = '0;
  int unsigned  last_wb_len = 0;

  function automatic logic [127:0] line_data(int unsigned n);
    if (bmem.exists(n)) return bmem[n];
    return {4{n}};
  endfunction

  function automatic logic [31:0] model_read(logic [31:0] a);
    logic [127:0] l;
    if (wr.exists(a)) return wr[a];
    l = line_data(a >> 4);
    return l[a[3:2]*32 +: 32];
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  // Monitor: every response is matched against the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && resp_valid) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got rdata %0h expected no response", resp_rdata);
        end else begin
          e = sbq.pop_front();
          chk("resp_rdata", resp_rdata, e.data);
          if (e.lat) chk("hit_latency", cyc - e.t, 2);
        end
      end
    end
  end

  // Write buffer: holds wb_ready low for wb_hold cycles, then accepts the line.
  initial begin
    bit           in_wb = 0;
    int unsigned  left = 0, len = 0;
    logic [31:0]  a0;
    logic [127:0] d0, exp_line;
    wb_ready = 0;
    forever begin
      @(negedge clk);
      wb_ready = 0;
      if (!rst_n) begin
        in_wb = 0;
      end else if (wb_valid) begin
        wb_seen++;
        chk("rd_req_during_wb", mem_rd_req, 0);
        if (!in_wb) begin
          in_wb = 1; left = wb_hold; len = 0; a0 = wb_addr; d0 = wb_data;
        end else begin
          chk("wb_addr_stable", wb_addr, a0);
          chk("wb_data_stable", wb_data, d0);
        end
        len++;
        if (left == 0) begin
          wb_ready = 1;
          in_wb = 0;
          wb_cnt++;
          last_wb_len = len;
          last_wb_addr = wb_addr;
          last_wb_data = wb_data;
          for (int w = 0; w < 4; w++) exp_line[w*32 +: 32] = model_read(wb_addr + 32'(w*4));
          chk("wb_line_content", wb_data, exp_line);
          bmem[wb_addr >> 4] = wb_data;
        end else begin
          left--;
        end
      end else if (spur_en && $urandom_range(0, 3) == 0) begin
        wb_ready = 1;
      end
    end
  end

  // Backing memory: answers refills after a random delay; injects stray beats.
  initial begin
    bit          in_rd = 0;
    int unsigned left = 0;
    mem_rd_valid = 0;
    mem_rd_data = '0;
    forever begin
      @(negedge clk);
      mem_rd_valid = 0;
      if (!rst_n) begin
        in_rd = 0;
      end else if (mem_rd_req) begin
        req_seen++;
        if (!mem_stall) begin
          if (!in_rd) begin
            in_rd = 1;
            left = $urandom_range(0, mem_dly_max);
            rd_cnt++;
            last_rd_addr = mem_rd_addr;
            chk("mem_rd_addr", mem_rd_addr, {cur_addr[31:4], 4'h0});
            chk("wb_valid_in_refill", wb_valid, 0);
          end
          if (left == 0) begin
            mem_rd_valid = 1;
            mem_rd_data = line_data(mem_rd_addr >> 4);
            in_rd = 0;
          end else begin
            left--;
          end
        end
      end else if (spur_en && $urandom_range(0, 7) == 0) begin
        mem_rd_valid = 1;
        mem_rd_data = {$urandom, $urandom, $urandom, $urandom};
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) fail_timeout("response");
  endtask

  task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input bit lat, input bit wait_done);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    while (!req_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      fail_timeout("req_ready");
      return;
    end
    req_valid = 1; req_wr = w; req_addr = a; req_wdata = d;
    cur_addr = a;
    e.data = w ? d : model_read(a);
    e.t = cyc;
    e.lat = lat;
    sbq.push_back(e);
    if (w) wr[a] = d;
    @(negedge clk);
    req_valid = 0; req_wr = 0;
    req_addr = {$urandom, 2'b00} & 32'hFFFF_FFFC;
    req_wdata = $urandom;
    if (wait_done) drain();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_rdata"}, resp_rdata, 0);
    chk({tag, "_wb_valid"}, wb_valid, 0);
    chk({tag, "_wb_addr"}, wb_addr, 0);
    chk({tag, "_wb_data"}, wb_data, 0);
    chk({tag, "_mem_rd_req"}, mem_rd_req, 0);
    chk({tag, "_mem_rd_addr"}, mem_rd_addr, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned s_req, s_rd, s_wb, s_wbc, n;
    logic [127:0] wline;
    logic [31:0]  a;

    req_valid = 0; req_wr = 0; req_addr = '0; req_wdata = '0;
    b_req_valid = 0; b_req_wr = 0; b_req_addr = '0; b_req_wdata = '0;
    b_wb_ready = 1; b_mem_rd_valid = 0; b_mem_rd_data = '0;

    rst_n = 1;
    #2 rst_n = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1;
    @(negedge clk);
    chk("ready_after_reset", req_ready, 1);

    // Small geometry: 32-byte lines, 64 sets, load of word 1 in line 9
    b_req_valid = 1; b_req_addr = 32'h124;
    @(negedge clk);
    b_req_valid = 0;
    n = 0;
    while (!b_mem_rd_req && n < 50) begin @(negedge clk); n++; end
    if (!b_mem_rd_req) fail_timeout("b_mem_rd_req");
    else chk("b_mem_rd_addr", b_mem_rd_addr, 32'h120);
    b_mem_rd_valid = 1; b_mem_rd_data = {8{32'd9}};
    @(negedge clk);
    b_mem_rd_valid = 0;
    n = 0;
    while (!b_resp_valid && n < 50) begin @(negedge clk); n++; end
    if (!b_resp_valid) fail_timeout("b_resp_valid");
    else chk("b_resp_rdata", b_resp_rdata, 32'd9);

    // Cold load of 0x10
    s_wb = wb_seen; s_rd = rd_cnt;
    issue(0, 32'h10, 0, 0, 1);
    chk("cold_refill_count", rd_cnt, s_rd + 1);
    chk("cold_refill_addr", last_rd_addr, 32'h10);
    chk("cold_no_wb", wb_seen, s_wb);

    // Repeat load hits with no memory traffic
    s_req = req_seen;
    issue(0, 32'h10, 0, 1, 1);
    chk("hit_no_rd_req", req_seen, s_req);

    // Store hit then load hit
    s_req = req_seen; s_wb = wb_seen;
    issue(1, 32'h14, 32'hDEADBEEF, 1, 1);
    issue(0, 32'h14, 0, 1, 1);
    chk("store_hit_no_rd_req", req_seen, s_req);
    chk("store_hit_no_wb", wb_seen, s_wb);

    // Fill the set, then evict the dirty 0x10 line under write-buffer backpressure
    issue(0, 32'h110, 0, 0, 1);
    issue(0, 32'h210, 0, 0, 1);
    issue(0, 32'h310, 0, 0, 1);
    s_wbc = wb_cnt;
    wb_hold = 3;
    issue(0, 32'h410, 0, 0, 1);
    wb_hold = 0;
    chk("evict_wb_count", wb_cnt, s_wbc + 1);
    chk("evict_wb_addr", last_wb_addr, 32'h10);
    wline = last_wb_data;
    chk("evict_wb_word1", wline[63:32], 32'hDEADBEEF);
    chk("evict_wb_len", last_wb_len, 4);
    chk("evict_refill_addr", last_rd_addr, 32'h410);
    s_req = req_seen;
    issue(0, 32'h110, 0, 1, 1);
    issue(0, 32'h210, 0, 1, 1);
    issue(0, 32'h310, 0, 1, 1);
    chk("other_ways_kept", req_seen, s_req);

    // Reset while a refill is outstanding
    mem_stall = 1;
    issue(0, 32'h10, 0, 0, 0);
    n = 0;
    while (!mem_rd_req && n < 50) begin @(negedge clk); n++; end
    if (!mem_rd_req) fail_timeout("refill_before_reset");
    rst_n = 0;
    #1;
    check_reset_outputs("midreset");
    sbq.delete();
    wr.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    mem_stall = 0;
    repeat (4) @(negedge clk);
    s_rd = rd_cnt;
    issue(0, 32'h10, 0, 0, 1);
    chk("reload_after_reset_misses", rd_cnt, s_rd + 1);

    // Randomized traffic over a small, conflict-heavy address range
    spur_en = 1;
    mem_dly_max = 3;
    for (int i = 0; i < 300; i++) begin
      wb_hold = $urandom_range(0, 3);
      a = (32'($urandom_range(0, 7)) << 8) | (32'($urandom_range(0, 3)) << 4) |
          (32'($urandom_range(0, 3)) << 2);
      issue(($urandom_range(0, 2) == 0), a, $urandom, 0, 1);
    end
    spur_en = 0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
